sbd_fifo_2w2r: RTL and testbench
================================

Name: sbd_fifo_2w2r

Overview:
- In-order scoreboard FIFO between the issuer (producer, up to 2 entries/cycle) and the committer (consumer, up to 2 entries/cycle).
- Each entry is one sbd_fifo_t: pipeline one-hot pl[4:0] plus pc. The committer peeks at the 2 oldest entries and dequeues 0, 1 or 2 of them each cycle.
- The whole FIFO is cleared by flush_i on a commit-error flush.

Parameters:
- Depth, 8: number of entries; must be a power of 2, ≥4.
- CHERIoTEn, 1'b0: passed through for package consistency; no functional effect.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- flush_i  in  1  synchronous clear of all entries
- wr_valid_i  in  2  write request for slot 0 / slot 1; slot 0 is the older entry
- wdata0_i  in  sbd_fifo_t  entry for write slot 0
- wdata1_i  in  sbd_fifo_t  entry for write slot 1
- wr_rdy_o  out  2  [0]: ≥1 free entry; [1]: ≥2 free entries
- rd_valid_o  out  2  [0]: ≥1 entry held; [1]: ≥2 entries held
- rdata0_o  out  sbd_fifo_t  oldest entry
- rdata1_o  out  sbd_fifo_t  second-oldest entry
- rd_rdy_i  in  2  dequeue request for oldest / second-oldest entry
- count_o  out  $clog2(Depth)+1  current occupancy

Behaviour:
- State:
  - wr_ptr_q, rd_ptr_q: $clog2(Depth) bits each, natural wrap modulo Depth.
  - count_q: $clog2(Depth)+1 bits.
  - Storage: array of Depth sbd_fifo_t, no reset.
- Reset values:
  - Pointers and count_q are 0.
  - rd_valid_o = 2'b00, wr_rdy_o = 2'b11, count_o = 0.
  - rdata*_o.pl = 0.
- Flags are registered-state only:
  - wr_rdy_o is derived from Depth−count_q.
  - rd_valid_o is derived from count_q.
  - No combinational path from rd_rdy_i to wr_rdy_o, or from wr_valid_i to rd_valid_o.
- Write side:
  - Accepted write for slot k: wr_en[k] = wr_valid_i[k] & wr_rdy_o[k] & ~flush_i.
  - wdata0 goes to mem[wr_ptr]; wdata1 goes to mem[wr_ptr+1] if slot 0 is also written.
  - wr_ptr advances by the number of accepted writes.
- Read side:
  - rdata0_o = mem[rd_ptr]; rdata1_o = mem[rd_ptr+1] (wrapped).
  - The pl field of rdataN_o is forced to 5'b0 when rd_valid_o[N]=0, so downstream same-pipeline compares stay X-free. The pc field passes through ungated.
  - Effective dequeue: rd_en[k] = rd_rdy_i[k] & rd_valid_o[k] & ~flush_i.
  - rd_ptr advances by the number of effective dequeues.
- Latency: an entry written in cycle N is visible on the rd ports in cycle N+1. There is no write-to-read bypass.
- Count: count_d = count_q + popcount(wr_en) − popcount(rd_en). Simultaneous write and read are allowed and update count consistently.
- Full boundary:
  - At count_q = Depth, wr_rdy_o = 00, even if a read happens in the same cycle.
  - At count_q = Depth−1, wr_rdy_o = 01; only slot 0 may be accepted.
- Empty boundary:
  - At count_q = 0, rd_valid_o = 00 and rd_rdy_i is ignored.
  - At count_q = 1, rd_rdy_i[1] is ignored.
- Protocol rules, checked by assertions (non-synthesis):
  - wr_valid_i[1] without wr_valid_i[0] is illegal.
  - rd_rdy_i[1] without rd_rdy_i[0] is illegal.
  - count_q never exceeds Depth.
  - Underflow and overflow never occur.
- Flush:
  - Next cycle: pointers and count are 0; rd_valid_o = 00.
  - Writes and reads presented in the flush cycle are discarded.
  - Storage contents are left unchanged.
- Reset mid-operation: asynchronous return to the reset values, regardless of count or flush.
- Wrap: pointer arithmetic is modulo Depth. A dual write or dual read straddling entry Depth−1 → 0 is required to work.

Decomposition:
- super_pkg:
  - sbd_fifo_t (pl[4:0], pc[31:0]) and a NULL_SBD_ENTRY constant, shared with the issuer and the committer.
  - The pipeline bit-index constants PL_ALU0=1, PL_ALU1=2, PL_LS=3, PL_MULT=4.
- No sub-module needed. A small function popcount2 may be local to the module.

Test Plan:
- Reset, then a dual write of {pl=00010, pc=0x100} and {pl=01000, pc=0x104} → next cycle rd_valid_o=11, rdata0_o.pc=0x100, rdata1_o.pc=0x104, count_o=2.
- Fill Depth=8 with single writes → count_o=7 gives wr_rdy_o=01; count_o=8 gives 00. A dual write at count 7 writes slot 0 only, and a simultaneous read leaves wr_rdy_o=00 that cycle.
- Leave one entry held, present rd_rdy_i=11 → only 1 dequeued, count_o=0, rdata1_o.pl=0 before and after.
- Advance the pointers to 7, dual write pc=0x200/0x204, dual read → entries wrap through mem[7] and mem[0] and come out in order 0x200, 0x204.
- With count=5, assert flush_i together with wr_valid_i=11 and rd_rdy_i=11 → next cycle count_o=0, rd_valid_o=00, wr_rdy_o=11, and no write is retained.
- Random stress against a queue scoreboard model, with 10k cycles of random valid/rdy and random flush at 2% → order and count always match and no assertion fires; rst_ni pulled low mid-burst restores reset values immediately.

Source files
------------

// File: rtl/super_pkg.sv
// Types and constants shared by the issuer, the scoreboard FIFO and the committer.
package super_pkg;

    typedef struct packed {
        logic [4:0]  pl;
        logic [31:0] pc;
    } sbd_fifo_t;

    localparam sbd_fifo_t NULL_SBD_ENTRY = '{pl: 5'b0, pc: 32'b0};

    // Bit positions inside the pl one-hot
    localparam int unsigned PL_ALU0 = 1;
    localparam int unsigned PL_ALU1 = 2;
    localparam int unsigned PL_LS   = 3;
    localparam int unsigned PL_MULT = 4;

endpackage

// File: rtl/sbd_fifo_2w2r.sv
// In-order scoreboard FIFO: two writes and two reads per cycle.
// Full/valid flags come only from registered occupancy.
module sbd_fifo_2w2r
    import super_pkg::*;
#(
    parameter int unsigned Depth     = 8,
    parameter bit          CHERIoTEn = 1'b0
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    flush_i,
    input  logic [1:0]              wr_valid_i,
    input  sbd_fifo_t               wdata0_i,
    input  sbd_fifo_t               wdata1_i,
    output logic [1:0]              wr_rdy_o,
    output logic [1:0]              rd_valid_o,
    output sbd_fifo_t               rdata0_o,
    output sbd_fifo_t               rdata1_o,
    input  logic [1:0]              rd_rdy_i,
    output logic [$clog2(Depth):0]  count_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] DepthC = CntW'(Depth);

    function automatic logic [1:0] popcount2(input logic [1:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]};
    endfunction

    sbd_fifo_t         mem [Depth];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [PtrW-1:0]   wr_ptr_nxt1, rd_ptr_nxt1;
    logic [CntW-1:0]   count_q, count_d;
    logic [1:0]        wr_en, rd_en;

    // Carries no behaviour here; kept so the parameter list matches the other users of the package.
    if (CHERIoTEn) begin : g_cheriot
    end

    assign wr_rdy_o[0]   = (count_q < DepthC);
    assign wr_rdy_o[1]   = (count_q < (DepthC - CntW'(1)));
    assign rd_valid_o[0] = (count_q != '0);
    assign rd_valid_o[1] = (count_q > CntW'(1));
    assign count_o       = count_q;

    // Slot 1 only ever follows slot 0, so a lone slot-1 request is never honoured.
    assign wr_en[0] = wr_valid_i[0] & wr_rdy_o[0] & ~flush_i;
    assign wr_en[1] = wr_valid_i[1] & wr_rdy_o[1] & wr_en[0];
    assign rd_en[0] = rd_rdy_i[0] & rd_valid_o[0] & ~flush_i;
    assign rd_en[1] = rd_rdy_i[1] & rd_valid_o[1] & rd_en[0];

    assign wr_ptr_nxt1 = wr_ptr_q + PtrW'(1);
    assign rd_ptr_nxt1 = rd_ptr_q + PtrW'(1);

    assign count_d = count_q + CntW'(popcount2(wr_en)) - CntW'(popcount2(rd_en));

    always_ff @(posedge clk_i) begin
        if (wr_en[0]) mem[wr_ptr_q]    <= wdata0_i;
        if (wr_en[1]) mem[wr_ptr_nxt1] <= wdata1_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + PtrW'(popcount2(wr_en));
            rd_ptr_q <= rd_ptr_q + PtrW'(popcount2(rd_en));
            count_q  <= count_d;
        end
    end

    // pl is zeroed on empty slots so downstream pipeline compares never see stale one-hots.
    always_comb begin
        rdata0_o = mem[rd_ptr_q];
        rdata1_o = mem[rd_ptr_nxt1];
        if (!rd_valid_o[0]) rdata0_o.pl = '0;
        if (!rd_valid_o[1]) rdata1_o.pl = '0;
    end

    a_wr_order: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(wr_valid_i[1] && !wr_valid_i[0]));
    a_rd_order: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(rd_rdy_i[1] && !rd_rdy_i[0]));
    a_count_max: assert property (@(posedge clk_i) disable iff (!rst_ni)
        count_q <= DepthC);
    a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        CntW'(popcount2(rd_en)) <= count_q);
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (count_q + CntW'(popcount2(wr_en))) <= DepthC);

endmodule

// File: tb/tb_sbd_fifo_2w2r.sv
// Bench for sbd_fifo_2w2r: vector table, directed corner sequences and random
// traffic, all checked against a queue model of the FIFO.
module tb_sbd_fifo_2w2r;
    import super_pkg::*;

    localparam int Depth = 8;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic            flush_i;
    logic [1:0]      wr_valid_i;
    sbd_fifo_t       wdata0_i, wdata1_i;
    logic [1:0]      wr_rdy_o, rd_valid_o, rd_rdy_i;
    sbd_fifo_t       rdata0_o, rdata1_o;
    logic [3:0]      count_o;

    int checks = 0;
    int errors = 0;
    sbd_fifo_t model_q[$];

    sbd_fifo_2w2r #(.Depth(Depth), .CHERIoTEn(1'b0)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_i    (flush_i),
        .wr_valid_i (wr_valid_i),
        .wdata0_i   (wdata0_i),
        .wdata1_i   (wdata1_i),
        .wr_rdy_o   (wr_rdy_o),
        .rd_valid_o (rd_valid_o),
        .rdata0_o   (rdata0_o),
        .rdata1_o   (rdata1_o),
        .rd_rdy_i   (rd_rdy_i),
        .count_o    (count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0]  wv;
        sbd_fifo_t   w0;
        sbd_fifo_t   w1;
        logic [1:0]  rr;
        logic        fl;
        logic [4:0]  cnt;
        logic [1:0]  rv;
        logic [1:0]  wr;
        logic        chk_pc;
        logic [31:0] pc0;
    } vec_t;

    vec_t vecs[7];

    function automatic sbd_fifo_t mk(input int unsigned pl_idx, input logic [31:0] pc);
        sbd_fifo_t e;
        e.pl = 5'(1) << pl_idx;
        e.pc = pc;
        return e;
    endfunction

    function automatic sbd_fifo_t rnd_entry();
        return mk($urandom_range(0, 4), $urandom);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        int n;
        n = model_q.size();
        chk("rd_valid", 64'(rd_valid_o), {62'b0, n >= 2, n >= 1});
        chk("wr_rdy",   64'(wr_rdy_o),   {62'b0, n <= Depth - 2, n <= Depth - 1});
        chk("count",    64'(count_o),    64'(n));
        if (n >= 1) chk("rdata0", 64'(rdata0_o), 64'(model_q[0]));
        else        chk("rdata0_pl", 64'(rdata0_o.pl), 64'd0);
        if (n >= 2) chk("rdata1", 64'(rdata1_o), 64'(model_q[1]));
        else        chk("rdata1_pl", 64'(rdata1_o.pl), 64'd0);
    endtask

    // Called just after an edge; drives inputs, predicts the next edge, then checks.
    task automatic step(input logic [1:0] wv, input sbd_fifo_t d0, input sbd_fifo_t d1,
                        input logic [1:0] rr, input logic fl);
        int n;
        bit a0, a1, r0, r1;
        wr_valid_i = wv;
        wdata0_i   = d0;
        wdata1_i   = d1;
        rd_rdy_i   = rr;
        flush_i    = fl;
        n  = model_q.size();
        a0 = wv[0] && (n <= Depth - 1) && !fl;
        a1 = a0 && wv[1] && (n <= Depth - 2);
        r0 = rr[0] && (n >= 1) && !fl;
        r1 = r0 && rr[1] && (n >= 2);
        @(posedge clk_i);
        if (fl) model_q.delete();
        else begin
            if (r0) void'(model_q.pop_front());
            if (r1) void'(model_q.pop_front());
            if (a0) model_q.push_back(d0);
            if (a1) model_q.push_back(d1);
        end
        #1;
        check_outputs();
    endtask

    task automatic idle(input logic [1:0] rr);
        step(2'b00, NULL_SBD_ENTRY, NULL_SBD_ENTRY, rr, 1'b0);
    endtask

    initial begin
        logic [1:0] wv, rr;
        rst_ni     = 1'b0;
        flush_i    = 1'b0;
        wr_valid_i = 2'b00;
        rd_rdy_i   = 2'b00;
        wdata0_i   = NULL_SBD_ENTRY;
        wdata1_i   = NULL_SBD_ENTRY;

        vecs[0] = '{2'b11, mk(PL_ALU0, 32'h100), mk(PL_LS, 32'h104), 2'b00, 1'b0, 5'd2, 2'b11, 2'b11, 1'b1, 32'h100};
        vecs[1] = '{2'b00, NULL_SBD_ENTRY, NULL_SBD_ENTRY, 2'b01, 1'b0, 5'd1, 2'b01, 2'b11, 1'b1, 32'h104};
        vecs[2] = '{2'b00, NULL_SBD_ENTRY, NULL_SBD_ENTRY, 2'b11, 1'b0, 5'd0, 2'b00, 2'b11, 1'b0, 32'h0};
        vecs[3] = '{2'b01, mk(PL_ALU1, 32'h110), NULL_SBD_ENTRY, 2'b00, 1'b0, 5'd1, 2'b01, 2'b11, 1'b1, 32'h110};
        vecs[4] = '{2'b11, mk(PL_MULT, 32'h114), mk(PL_ALU0, 32'h118), 2'b01, 1'b0, 5'd2, 2'b11, 2'b11, 1'b1, 32'h114};
        vecs[5] = '{2'b01, mk(PL_LS, 32'h11c), NULL_SBD_ENTRY, 2'b11, 1'b0, 5'd1, 2'b01, 2'b11, 1'b1, 32'h11c};
        vecs[6] = '{2'b00, NULL_SBD_ENTRY, NULL_SBD_ENTRY, 2'b01, 1'b0, 5'd0, 2'b00, 2'b11, 1'b0, 32'h0};

        repeat (2) @(posedge clk_i);
        #1;
        check_outputs();
        chk("reset_count", 64'(count_o), 64'd0);
        chk("reset_wr_rdy", 64'(wr_rdy_o), 64'd3);
        rst_ni = 1'b1;

        for (int i = 0; i < 7; i++) begin
            step(vecs[i].wv, vecs[i].w0, vecs[i].w1, vecs[i].rr, vecs[i].fl);
            chk($sformatf("vec%0d_count", i), 64'(count_o), 64'(vecs[i].cnt));
            chk($sformatf("vec%0d_rd_valid", i), 64'(rd_valid_o), 64'(vecs[i].rv));
            chk($sformatf("vec%0d_wr_rdy", i), 64'(wr_rdy_o), 64'(vecs[i].wr));
            if (vecs[i].chk_pc) chk($sformatf("vec%0d_pc0", i), 64'(rdata0_o.pc), 64'(vecs[i].pc0));
        end

        // Fill to the full boundary
        for (int i = 0; i < 7; i++)
            step(2'b01, mk(PL_ALU0, 32'h300 + 32'(4 * i)), NULL_SBD_ENTRY, 2'b00, 1'b0);
        chk("fill7_wr_rdy", 64'(wr_rdy_o), 64'd1);
        step(2'b01, mk(PL_ALU1, 32'h31c), NULL_SBD_ENTRY, 2'b00, 1'b0);
        chk("fill8_wr_rdy", 64'(wr_rdy_o), 64'd0);
        idle(2'b01);
        chk("c7_count", 64'(count_o), 64'd7);
        step(2'b11, mk(PL_LS, 32'h320), mk(PL_MULT, 32'h324), 2'b00, 1'b0);
        chk("dual_at7_count", 64'(count_o), 64'd8);
        chk("full_wr_rdy", 64'(wr_rdy_o), 64'd0);
        step(2'b11, mk(PL_LS, 32'h328), mk(PL_MULT, 32'h32c), 2'b01, 1'b0);
        chk("full_rd_count", 64'(count_o), 64'd7);
        repeat (3) idle(2'b11);
        idle(2'b01);
        chk("drain_count", 64'(count_o), 64'd0);

        // Both pointers now sit at Depth-1, so the next pair straddles the wrap
        step(2'b11, mk(PL_ALU1, 32'h200), mk(PL_MULT, 32'h204), 2'b00, 1'b0);
        chk("wrap_pc0", 64'(rdata0_o.pc), 64'h200);
        chk("wrap_pc1", 64'(rdata1_o.pc), 64'h204);
        idle(2'b11);
        chk("wrap_drain", 64'(count_o), 64'd0);

        step(2'b11, rnd_entry(), rnd_entry(), 2'b00, 1'b0);
        step(2'b11, rnd_entry(), rnd_entry(), 2'b00, 1'b0);
        step(2'b01, rnd_entry(), NULL_SBD_ENTRY, 2'b00, 1'b0);
        chk("pre_flush_count", 64'(count_o), 64'd5);
        step(2'b11, rnd_entry(), rnd_entry(), 2'b11, 1'b1);
        chk("flush_count", 64'(count_o), 64'd0);
        chk("flush_rd_valid", 64'(rd_valid_o), 64'd0);
        chk("flush_wr_rdy", 64'(wr_rdy_o), 64'd3);
        idle(2'b00);
        chk("post_flush_count", 64'(count_o), 64'd0);

        for (int i = 0; i < 10000; i++) begin
            if (i == 5000) begin
                step(2'b11, rnd_entry(), rnd_entry(), 2'b00, 1'b0);
                step(2'b11, rnd_entry(), rnd_entry(), 2'b00, 1'b0);
                rst_ni = 1'b0;
                #1;
                chk("midrst_count", 64'(count_o), 64'd0);
                chk("midrst_rd_valid", 64'(rd_valid_o), 64'd0);
                chk("midrst_wr_rdy", 64'(wr_rdy_o), 64'd3);
                chk("midrst_pl0", 64'(rdata0_o.pl), 64'd0);
                chk("midrst_pl1", 64'(rdata1_o.pl), 64'd0);
                model_q.delete();
                #1;
                rst_ni = 1'b1;
            end
            case ($urandom_range(0, 2))
                0: wv = 2'b00;
                1: wv = 2'b01;
                default: wv = 2'b11;
            endcase
            case ($urandom_range(0, 2))
                0: rr = 2'b00;
                1: rr = 2'b01;
                default: rr = 2'b11;
            endcase
            step(wv, rnd_entry(), rnd_entry(), rr, ($urandom_range(0, 99) < 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
